seg_scan_ctrl: RTL
==================

// Module: seg_scan_ctrl
// PURPOSE
//  Time-multiplexed scan controller for the GPIO-driven big 7-segment display.
//  Cycles through NUM_DIGITS digits, driving one-hot digit select and active-high segments.
//  Inserts a blanking gap between digits to suppress ghosting.
//  Takes new digit data from the bcdto7seg decoders through a req/ack handshake, applied only on frame boundaries.
// PARAMETERS
//  NUM_DIGITS    4       digits scanned per frame (2..8)
//  DWELL_CYCLES  131072  clocks each digit is lit (>=2); 131072 = 2^17 clocks at 50 MHz
//  BLANK_CYCLES  64      clocks of all-off between digits (0 = no blanking)
// PORTS
//  CLOCK_50     in   1              system clock, 50 MHz
//  reset        in   1              async, active-low (KEY[0]); 0 = reset
//  enable       in   1              1 = scan running; 0 = display dark
//  seg_n_in     in   7*NUM_DIGITS   active-low segments from decoders; digit k = [7k+6:7k]
//  load_req     in   1              new seg_n_in valid; held until load_ack
//  load_ack     out  1              1-cycle pulse: seg_n_in captured into shadow register
//  bigseg       out  7              active-high segments to GPIO[6:0]
//  sel          out  NUM_DIGITS     one-hot digit select to GPIO; bit k = digit k lit
//  digit_idx    out  $clog2(NUM_DIGITS)  index of the current/next digit
//  frame_start  out  1              1-cycle pulse when digit 0 begins DWELL
// BEHAVIOUR
//  Reset (async assert, sync release), all outputs registered:
//   - state=IDLE; bigseg=0; sel=0; digit_idx=0; load_ack=0; frame_start=0; shadow=all-ones (blank).
//  FSM, states IDLE, BLANK, DWELL:
//   - IDLE: sel=0, bigseg=0. On enable=1 go to DWELL for digit 0 (BLANK first if BLANK_CYCLES>0).
//   - BLANK: sel=0, bigseg=0 for exactly BLANK_CYCLES clocks, then DWELL.
//   - DWELL: sel=1<<digit_idx, bigseg=~shadow[digit_idx] for exactly DWELL_CYCLES clocks.
//     Then digit_idx advances and the FSM goes to BLANK (or straight to DWELL if BLANK_CYCLES=0).
//   - digit_idx wraps NUM_DIGITS-1 -> 0; the wrap is the frame boundary.
//   - sel and bigseg change in the same clock; sel is never non-zero with stale segments.
//  Timer:
//   - one down-counter, width $clog2(max(DWELL_CYCLES,BLANK_CYCLES)+1).
//   - reloaded on every state entry; the state exits when the counter reaches 1.
//   - frame period = NUM_DIGITS*(DWELL_CYCLES+BLANK_CYCLES) exactly.
//  Load handshake:
//   - load_req sampled only in the cycle the frame boundary is crossed (entry to digit 0).
//   - If req=1: shadow<=seg_n_in and load_ack=1 in that same cycle.
//   - Digit 0's DWELL then shows the new data, so a frame is never torn.
//   - Requester keeps seg_n_in stable while load_req=1 and drops req the cycle after ack.
//   - load_req=1 while in IDLE: captured on the IDLE->scan transition, with ack.
//  frame_start: pulses on the first DWELL cycle of digit 0, including the first frame after enable.
//  enable=0 mid-scan: next clock goes to IDLE, sel=0, bigseg=0, digit_idx=0, timer cleared.
//   - Any pending load_req is not acked until the next boundary.
//  enable re-asserted: restart at digit 0; shadow is retained.
//  Reset mid-frame: immediate return to reset values; shadow reverts to blank.
// STRUCTURE
//  Shared package seg_pkg:
//   - state encoding localparams (IDLE/BLANK/DWELL).
//   - SEG_W=7, SEG_BLANK_N=7'h7F.
//  One sub-module scan_timer: loadable down-counter with a done flag.
//  FSM, shadow register and output registers are flat in seg_scan_ctrl.
// TESTING (NUM_DIGITS=4, DWELL_CYCLES=8, BLANK_CYCLES=2)
//  1 Reset then enable=1, no load -> sel walks 0001,0010,0100,1000 every 10 clocks; bigseg=0 throughout.
//  2 seg_n_in={7'h40,7'h79,7'h24,7'h30}, load_req at mid-frame -> ack exactly at next wrap.
//    Digit 0 bigseg=7'h4F; digits 1,2,3 show 7'h5B,7'h06,7'h3F.
//  3 seg_n_in changes while load_req=0 -> displayed segments unchanged for >=3 frames.
//  4 enable dropped during digit 2 DWELL -> next clock sel=0, bigseg=0, digit_idx=0.
//    Re-enable -> frame_start and digit 0 after 2 BLANK clocks.
//  5 reset asserted mid-DWELL -> outputs 0 asynchronously.
//    After release + load, old data absent: shadow was blanked.
//  6 BLANK_CYCLES=0 rebuild -> sel steps every 8 clocks with no all-zero gap.
//    Frame period = 32 clocks.

Source files
------------

// File: rtl/seg_scan_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg_pkg
//  Description : Shared constants and types for the 7-segment scan controller.
//                The package holds the segment width, the active-low blank
//                pattern, the FSM state encoding and a small sizing helper.
//  Revision    : 1.0  initial release
// ============================================================================
package seg_pkg;

  localparam int SEG_W = 7;
  localparam logic [SEG_W-1:0] SEG_BLANK_N = 7'h7F;

  // These constants fix the FSM state encoding.
  localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
  localparam logic [1:0] ST_BLANK_ENC = 2'd1;
  localparam logic [1:0] ST_DWELL_ENC = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = ST_IDLE_ENC,
    ST_BLANK = ST_BLANK_ENC,
    ST_DWELL = ST_DWELL_ENC
  } scan_state_e;

  // Used for timer sizing, so it must be usable in constant expressions.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : seg_scan_ctrl_if
//  Description : Bus between the decoder side (master) and the scan
//                controller (slave).
//    enable      master->slave  1 = scan running
//    seg_n_in    master->slave  active-low segments; digit k = [7k+6:7k]
//    load_req    master->slave  seg_n_in valid, held until load_ack
//    load_ack    slave->master  1-cycle capture pulse
//    bigseg      slave->master  active-high segments
//    sel         slave->master  one-hot digit select
//    digit_idx   slave->master  current/next digit index
//    frame_start slave->master  pulse on first DWELL cycle of digit 0
//  Revision    : 1.0  initial release
// ============================================================================
interface seg_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4
);
  import seg_pkg::*;

  localparam int IDX_W = $clog2(NUM_DIGITS);

  logic                        enable;
  logic [SEG_W*NUM_DIGITS-1:0] seg_n_in;
  logic                        load_req;
  logic                        load_ack;
  logic [SEG_W-1:0]            bigseg;
  logic [NUM_DIGITS-1:0]       sel;
  logic [IDX_W-1:0]            digit_idx;
  logic                        frame_start;

  modport master (
    output enable, seg_n_in, load_req,
    input  load_ack, bigseg, sel, digit_idx, frame_start
  );

  modport slave (
    input  enable, seg_n_in, load_req,
    output load_ack, bigseg, sel, digit_idx, frame_start
  );

endinterface
`default_nettype wire

// File: rtl/seg_scan_ctrl_scan_timer.sv
`default_nettype none
// ============================================================================
//  Module      : scan_timer
//  Description : Loadable down-counter for the scan controller.
//                A load sets the count to the number of cycles the new state
//                lasts. o_done is high in the last cycle of that state, when
//                the count is 1. A clear forces the count to zero.
//    clk, rst_n    clock and asynchronous active-low reset
//    i_clr         force count to zero
//    i_load        load i_load_val (i_clr has priority)
//    i_load_val    cycles the new state lasts
//    o_done        count == 1
//  Revision    : 1.0  initial release
// ============================================================================
module scan_timer #(
  parameter int WIDTH = 4
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             i_clr,
  input  wire logic             i_load,
  input  wire logic [WIDTH-1:0] i_load_val,
  output logic                  o_done
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_done = (r_count == WIDTH'(1));

endmodule
`default_nettype wire

// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : seg_scan_ctrl
//  Description : Time-multiplexed scan controller for a multi-digit
//                7-segment display. It lights one digit at a time for
//                DWELL_CYCLES clocks. It inserts BLANK_CYCLES all-off clocks
//                between digits. New digit data is taken only at the frame
//                boundary, so a frame is never torn.
//    CLOCK_50   system clock
//    reset      asynchronous active-low reset
//    bus        seg_scan_ctrl_if.slave (enable, seg_n_in, load_req in;
//               load_ack, bigseg, sel, digit_idx, frame_start out)
//  Revision    : 1.0  initial release
// ============================================================================
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int DWELL_CYCLES = 131072,
  parameter int BLANK_CYCLES = 64
) (
  input  wire logic     CLOCK_50,
  input  wire logic     reset,
  seg_scan_ctrl_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int TMR_W = $clog2(max_int(DWELL_CYCLES, BLANK_CYCLES) + 1);

  localparam bit               c_HAS_BLANK = (BLANK_CYCLES > 0);
  localparam logic [TMR_W-1:0] c_DWELL_LD  = TMR_W'(DWELL_CYCLES);
  localparam logic [TMR_W-1:0] c_BLANK_LD  = TMR_W'(BLANK_CYCLES);
  // After each DWELL, and on leaving IDLE, the FSM enters this state's load value.
  localparam logic [TMR_W-1:0] c_GAP_LD    = c_HAS_BLANK ? c_BLANK_LD : c_DWELL_LD;
  localparam logic [IDX_W-1:0] c_LAST_IDX  = IDX_W'(NUM_DIGITS - 1);

  scan_state_e                          r_state;
  logic [NUM_DIGITS-1:0][SEG_W-1:0]     r_shadow;
  logic [IDX_W-1:0]                     r_digit_idx;
  logic [NUM_DIGITS-1:0]                r_sel;
  logic [SEG_W-1:0]                     r_bigseg;
  logic                                 r_load_ack;
  logic                                 r_frame_start;

  logic                                 w_tmr_done;
  logic                                 w_tmr_clr;
  logic                                 w_tmr_load;
  logic [TMR_W-1:0]                     w_tmr_val;
  logic                                 w_boundary;
  logic                                 w_take;
  logic                                 w_last_digit;
  logic [IDX_W-1:0]                     w_idx_inc;
  logic [NUM_DIGITS-1:0][SEG_W-1:0]     w_shadow_nxt;

  function automatic logic [NUM_DIGITS-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_DIGITS-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  assign w_last_digit = (r_digit_idx == c_LAST_IDX);
  assign w_idx_inc    = w_last_digit ? '0 : r_digit_idx + 1'b1;

  // Timer control and frame-boundary detection. The boundary is the clock in
  // which digit 0 is entered: leaving IDLE, or finishing the last digit.
  always_comb begin
    w_tmr_clr  = 1'b0;
    w_tmr_load = 1'b0;
    w_tmr_val  = '0;
    w_boundary = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (bus.enable) begin
          w_tmr_load = 1'b1;
          w_tmr_val  = c_GAP_LD;
          w_boundary = 1'b1;
        end else begin
          w_tmr_clr  = 1'b1;
        end
      end
      ST_BLANK: begin
        if (!bus.enable) begin
          w_tmr_clr  = 1'b1;
        end else if (w_tmr_done) begin
          w_tmr_load = 1'b1;
          w_tmr_val  = c_DWELL_LD;
        end
      end
      ST_DWELL: begin
        if (!bus.enable) begin
          w_tmr_clr  = 1'b1;
        end else if (w_tmr_done) begin
          w_tmr_load = 1'b1;
          w_tmr_val  = c_GAP_LD;
          w_boundary = w_last_digit;
        end
      end
      default: begin
        w_tmr_clr  = 1'b1;
      end
    endcase
  end

  assign w_take = w_boundary & bus.load_req;

  // Without blanking, digit 0 is lit in the same clock as the capture.
  // The segment lookup must therefore see the incoming data.
  assign w_shadow_nxt = w_take ? bus.seg_n_in : r_shadow;

  scan_timer #(
    .WIDTH (TMR_W)
  ) u_timer (
    .clk        (CLOCK_50),
    .rst_n      (reset),
    .i_clr      (w_tmr_clr),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_done     (w_tmr_done)
  );

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_shadow      <= {NUM_DIGITS{SEG_BLANK_N}};
      r_digit_idx   <= '0;
      r_sel         <= '0;
      r_bigseg      <= '0;
      r_load_ack    <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_load_ack    <= 1'b0;
      r_frame_start <= 1'b0;
      if (w_take) begin
        r_shadow   <= bus.seg_n_in;
        r_load_ack <= 1'b1;
      end
      unique case (r_state)
        ST_IDLE: begin
          r_sel       <= '0;
          r_bigseg    <= '0;
          r_digit_idx <= '0;
          if (bus.enable) begin
            if (c_HAS_BLANK) begin
              r_state <= ST_BLANK;
            end else begin
              r_state       <= ST_DWELL;
              r_sel         <= onehot('0);
              r_bigseg      <= ~w_shadow_nxt[0];
              r_frame_start <= 1'b1;
            end
          end
        end
        ST_BLANK: begin
          if (!bus.enable) begin
            r_state     <= ST_IDLE;
            r_sel       <= '0;
            r_bigseg    <= '0;
            r_digit_idx <= '0;
          end else if (w_tmr_done) begin
            r_state       <= ST_DWELL;
            r_sel         <= onehot(r_digit_idx);
            r_bigseg      <= ~r_shadow[r_digit_idx];
            r_frame_start <= (r_digit_idx == '0);
          end
        end
        ST_DWELL: begin
          if (!bus.enable) begin
            r_state     <= ST_IDLE;
            r_sel       <= '0;
            r_bigseg    <= '0;
            r_digit_idx <= '0;
          end else if (w_tmr_done) begin
            r_digit_idx <= w_idx_inc;
            if (c_HAS_BLANK) begin
              r_state  <= ST_BLANK;
              r_sel    <= '0;
              r_bigseg <= '0;
            end else begin
              r_state       <= ST_DWELL;
              r_sel         <= onehot(w_idx_inc);
              r_bigseg      <= ~w_shadow_nxt[w_idx_inc];
              r_frame_start <= w_last_digit;
            end
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_sel       <= '0;
          r_bigseg    <= '0;
          r_digit_idx <= '0;
        end
      endcase
    end
  end

  assign bus.load_ack    = r_load_ack;
  assign bus.bigseg      = r_bigseg;
  assign bus.sel         = r_sel;
  assign bus.digit_idx   = r_digit_idx;
  assign bus.frame_start = r_frame_start;

endmodule
`default_nettype wire
